// File: rtl/traffic_light_pkg.sv
// Shared constants for the traffic-light board monitor: segment codes,
// legal lamp patterns and road encodings.
package traffic_light_pkg;

    // Active-low 7-segment codes, bit 6 = segment g ... bit 0 = segment a
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    // The only lamp patterns the controller is allowed to show
    localparam logic [4:0] LED_LEGAL_0 = 5'b00011;
    localparam logic [4:0] LED_LEGAL_1 = 5'b01000;
    localparam logic [4:0] LED_LEGAL_2 = 5'b10100;
    localparam logic [4:0] LED_LEGAL_3 = 5'b10000;
    localparam logic [4:0] LED_LEGAL_4 = 5'b00100;

    typedef enum logic [1:0] {
        ROAD_IDLE = 2'd0,
        ROAD_A    = 2'd1,
        ROAD_B    = 2'd2,
        ROAD_C    = 2'd3
    } road_e;

    function automatic logic isLegalLed(input logic [4:0] led);
        return (led == LED_LEGAL_0) || (led == LED_LEGAL_1) ||
               (led == LED_LEGAL_2) || (led == LED_LEGAL_3) ||
               (led == LED_LEGAL_4);
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Maps an active-low 7-segment code back to its hex nibble; unknown codes
// decode to 0 with valid deasserted.
module seg7_decoder
    import traffic_light_pkg::*;
(
    input  logic [6:0] code_i,
    output logic [3:0] value_o,
    output logic       valid_o
);

    // Reverse lookup of the segment table
    always_comb begin
        value_o = 4'h0;
        valid_o = 1'b1;
        case (code_i)
            SEG_0:   value_o = 4'h0;
            SEG_1:   value_o = 4'h1;
            SEG_2:   value_o = 4'h2;
            SEG_3:   value_o = 4'h3;
            SEG_4:   value_o = 4'h4;
            SEG_5:   value_o = 4'h5;
            SEG_6:   value_o = 4'h6;
            SEG_7:   value_o = 4'h7;
            SEG_8:   value_o = 4'h8;
            SEG_9:   value_o = 4'h9;
            SEG_A:   value_o = 4'hA;
            SEG_B:   value_o = 4'hB;
            SEG_C:   value_o = 4'hC;
            SEG_D:   value_o = 4'hD;
            SEG_E:   value_o = 4'hE;
            SEG_F:   value_o = 4'hF;
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the traffic-light board: samples lamps and displays
// once per controller tick, decodes them and flags protocol violations.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK_50MHz,
    input  logic       Res_n,
    input  logic       Counter,
    input  logic [4:0] LED,
    input  logic [6:0] Seg4,
    input  logic [6:0] Seg3,
    input  logic [6:0] Seg2,
    input  logic [6:0] Seg1,
    output logic [1:0] Road,
    output logic [3:0] Digit3,
    output logic [3:0] Digit2,
    output logic [3:0] Digit1,
    output logic [3:0] Remain,
    output logic       Tick_Pulse,
    output logic       Err_Seg,
    output logic       Err_LED,
    output logic       Err_Count,
    output logic [7:0] Err_Total
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   syncLast_q;
    logic                   tickDet_q;
    logic                   capValid_q;
    logic [4:0]             ledCap_q;
    logic [6:0]             seg4Cap_q, seg3Cap_q, seg2Cap_q, seg1Cap_q;

    road_e                  road_q, road_d;
    logic [3:0]             digit3_q, digit2_q, digit1_q, remain_q, remain_d;
    logic                   tickPulse_q;
    logic                   errSeg_q, errLed_q, errCount_q;
    logic [7:0]             errTotal_q, errTotal_d;
    logic                   prevValid_q;
    road_e                  prevRoad_q;
    logic [4:0]             prevLed_q;
    logic [3:0]             prevRemain_q;

    logic [3:0]             val4, val3, val2, val1;
    logic                   ok4, ok3, ok2, ok1;
    logic                   segErr_d, ledErr_d, countErr_d, active_d;

    seg7_decoder u_dec4 (.code_i(seg4Cap_q), .value_o(val4), .valid_o(ok4));
    seg7_decoder u_dec3 (.code_i(seg3Cap_q), .value_o(val3), .valid_o(ok3));
    seg7_decoder u_dec2 (.code_i(seg2Cap_q), .value_o(val2), .valid_o(ok2));
    seg7_decoder u_dec1 (.code_i(seg1Cap_q), .value_o(val1), .valid_o(ok1));

    // Synchronise Counter, register its edge, then capture the board inputs
    always_ff @(posedge CLK_50MHz or negedge Res_n) begin
        if (!Res_n) begin
            sync_q     <= '0;
            syncLast_q <= 1'b0;
            tickDet_q  <= 1'b0;
            capValid_q <= 1'b0;
            ledCap_q   <= '0;
            seg4Cap_q  <= '0;
            seg3Cap_q  <= '0;
            seg2Cap_q  <= '0;
            seg1Cap_q  <= '0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], Counter};
            syncLast_q <= sync_q[SYNC_STAGES-1];
            tickDet_q  <= sync_q[SYNC_STAGES-1] ^ syncLast_q;
            capValid_q <= tickDet_q;
            if (tickDet_q) begin
                ledCap_q  <= LED;
                seg4Cap_q <= Seg4;
                seg3Cap_q <= Seg3;
                seg2Cap_q <= Seg2;
                seg1Cap_q <= Seg1;
            end
        end
    end

    // Evaluate the captured sample against the previous one
    always_comb begin
        road_d   = ROAD_IDLE;
        segErr_d = !(ok4 && ok3 && ok2 && ok1);
        if (ok4) begin
            case (val4)
                4'h0:    road_d = ROAD_IDLE;
                4'hA:    road_d = ROAD_A;
                4'hB:    road_d = ROAD_B;
                4'hC:    road_d = ROAD_C;
                default: segErr_d = 1'b1;
            endcase
        end
        remain_d = val1;
        if (val2 > remain_d) remain_d = val2;
        if (val3 > remain_d) remain_d = val3;
        active_d   = (road_d != ROAD_IDLE);
        ledErr_d   = active_d && !isLegalLed(ledCap_q);
        countErr_d = active_d && prevValid_q && (road_d == prevRoad_q) &&
                     (ledCap_q == prevLed_q) && (prevRemain_q != 4'd0) &&
                     (remain_d != (prevRemain_q - 4'd1));
        errTotal_d = errTotal_q;
        if ((segErr_d || ledErr_d || countErr_d) && (errTotal_q != 8'hFF))
            errTotal_d = errTotal_q + 8'd1;
    end

    // Publish results, accumulate sticky errors and keep the previous context
    always_ff @(posedge CLK_50MHz or negedge Res_n) begin
        if (!Res_n) begin
            road_q       <= ROAD_IDLE;
            digit3_q     <= '0;
            digit2_q     <= '0;
            digit1_q     <= '0;
            remain_q     <= '0;
            tickPulse_q  <= 1'b0;
            errSeg_q     <= 1'b0;
            errLed_q     <= 1'b0;
            errCount_q   <= 1'b0;
            errTotal_q   <= '0;
            prevValid_q  <= 1'b0;
            prevRoad_q   <= ROAD_IDLE;
            prevLed_q    <= '0;
            prevRemain_q <= '0;
        end else begin
            tickPulse_q <= capValid_q;
            if (capValid_q) begin
                road_q     <= road_d;
                digit3_q   <= val3;
                digit2_q   <= val2;
                digit1_q   <= val1;
                remain_q   <= remain_d;
                errSeg_q   <= errSeg_q | segErr_d;
                errLed_q   <= errLed_q | ledErr_d;
                errCount_q <= errCount_q | countErr_d;
                errTotal_q <= errTotal_d;
                if (active_d) begin
                    prevValid_q  <= 1'b1;
                    prevRoad_q   <= road_d;
                    prevLed_q    <= ledCap_q;
                    prevRemain_q <= remain_d;
                end else begin
                    prevValid_q  <= 1'b0;
                end
            end
        end
    end

    assign Road       = road_q;
    assign Digit3     = digit3_q;
    assign Digit2     = digit2_q;
    assign Digit1     = digit1_q;
    assign Remain     = remain_q;
    assign Tick_Pulse = tickPulse_q;
    assign Err_Seg    = errSeg_q;
    assign Err_LED    = errLed_q;
    assign Err_Count  = errCount_q;
    assign Err_Total  = errTotal_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for the traffic-light monitor: drives board samples one
// controller tick at a time and compares against hand-computed results.
module tb_traffic_light_monitor;

    logic       clk = 1'b0;
    logic       resN = 1'b0;
    logic       counter = 1'b0;
    logic [4:0] led = 5'b0;
    logic [6:0] seg4 = 7'b1000000, seg3 = 7'b1000000;
    logic [6:0] seg2 = 7'b1000000, seg1 = 7'b1000000;
    logic [1:0] road;
    logic [3:0] digit3, digit2, digit1, remain;
    logic       tickPulse, errSeg, errLed, errCount;
    logic [7:0] errTotal;

    int passCount = 0;
    int checkCount = 0;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SB = 7'b0000011;
    localparam logic [6:0] SC = 7'b1000110;
    localparam logic [6:0] SD = 7'b0100001;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] BAD = 7'b1111111;

    traffic_light_monitor #(.SYNC_STAGES(2)) dut (
        .CLK_50MHz (clk),
        .Res_n     (resN),
        .Counter   (counter),
        .LED       (led),
        .Seg4      (seg4),
        .Seg3      (seg3),
        .Seg2      (seg2),
        .Seg1      (seg1),
        .Road      (road),
        .Digit3    (digit3),
        .Digit2    (digit2),
        .Digit1    (digit1),
        .Remain    (remain),
        .Tick_Pulse(tickPulse),
        .Err_Seg   (errSeg),
        .Err_LED   (errLed),
        .Err_Count (errCount),
        .Err_Total (errTotal)
    );

    always #10 clk = ~clk;

    // One compared value; the pass counter feeds the summary line
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Present one board sample, toggle Counter and wait for the result strobe
    task automatic applyStimulus(input logic [4:0] l, input logic [6:0] s4,
                                 input logic [6:0] s3, input logic [6:0] s2,
                                 input logic [6:0] s1);
        logic seen;
        @(negedge clk);
        led = l; seg4 = s4; seg3 = s3; seg2 = s2; seg1 = s1;
        counter = ~counter;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (tickPulse) seen = 1'b1;
        end
        checkOutput("tick_pulse_seen", {31'b0, seen}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [6:0] segOf(input int n);
        case (n)
            0: return S0;  1: return S1;  2: return S2;  3: return S3;
            4: return S4;  5: return S5;  6: return S6;  7: return S7;
            8: return S8;  9: return S9;  10: return SA; 11: return SB;
            12: return SC; 13: return SD; default: return SE;
        endcase
    endfunction

    int remA [21] = '{5, 4, 3, 2, 1, 2, 1, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};

    initial begin
        logic [4:0] stepLed;
        logic       sawPulse;
        $display("[TB] start");
        repeat (3) @(negedge clk);

        checkOutput("rst_road", {30'b0, road}, 32'd0);
        checkOutput("rst_digits", {20'b0, digit3, digit2, digit1}, 32'd0);
        checkOutput("rst_remain", {28'b0, remain}, 32'd0);
        checkOutput("rst_tick", {31'b0, tickPulse}, 32'd0);
        checkOutput("rst_flags", {29'b0, errSeg, errLed, errCount}, 32'd0);
        checkOutput("rst_total", {24'b0, errTotal}, 32'd0);
        resN = 1'b1;
        repeat (3) @(negedge clk);

        // Road A: two full 21-step cycles
        for (int c = 0; c < 2; c++) begin
            for (int s = 0; s < 21; s++) begin
                if (s < 5 || s == 20) stepLed = 5'b00011;
                else if (s < 7) stepLed = 5'b00100;
                else stepLed = 5'b10000;
                if (s < 5) applyStimulus(stepLed, SA, S0, segOf(remA[s]), S0);
                else applyStimulus(stepLed, SA, S0, S0, segOf(remA[s]));
                checkOutput("roadA_road", {30'b0, road}, 32'd1);
                checkOutput("roadA_remain", {28'b0, remain}, remA[s]);
                checkOutput("roadA_flags", {29'b0, errSeg, errLed, errCount}, 32'd0);
                if (s == 0) checkOutput("roadA_digit2", {28'b0, digit2}, 32'd5);
            end
        end
        checkOutput("roadA_total", {24'b0, errTotal}, 32'd0);

        // Bad segment code on Seg1
        applyStimulus(5'b00011, SA, S0, S3, BAD);
        checkOutput("badseg_flag", {31'b0, errSeg}, 32'd1);
        checkOutput("badseg_digit1", {28'b0, digit1}, 32'd0);
        checkOutput("badseg_remain", {28'b0, remain}, 32'd3);
        checkOutput("badseg_total", {24'b0, errTotal}, 32'd1);
        checkOutput("badseg_other", {30'b0, errLed, errCount}, 32'd0);
        applyStimulus(5'b00011, SA, S0, S2, S0);
        applyStimulus(5'b00011, SA, S0, S1, S0);
        applyStimulus(5'b00011, SA, S0, S0, S0);
        applyStimulus(5'b00011, SA, S0, S5, S0);
        applyStimulus(5'b00011, SA, S0, S4, S0);
        checkOutput("badseg_sticky", {31'b0, errSeg}, 32'd1);
        checkOutput("badseg_total_hold", {24'b0, errTotal}, 32'd1);
        checkOutput("badseg_count_clean", {31'b0, errCount}, 32'd0);

        // Illegal lamp pattern
        applyStimulus(5'b11111, SA, S0, S0, S3);
        checkOutput("lamp_flag", {31'b0, errLed}, 32'd1);
        checkOutput("lamp_count", {31'b0, errCount}, 32'd0);
        checkOutput("lamp_total", {24'b0, errTotal}, 32'd2);

        // Skipped count 9 -> 7
        applyStimulus(5'b10000, SA, S0, S0, S9);
        checkOutput("skip_first", {24'b0, errTotal}, 32'd2);
        applyStimulus(5'b10000, SA, S0, S0, S7);
        checkOutput("skip_flag", {31'b0, errCount}, 32'd1);
        checkOutput("skip_total", {24'b0, errTotal}, 32'd3);
        applyStimulus(5'b10000, SA, S0, S0, S6);
        checkOutput("skip_resume", {24'b0, errTotal}, 32'd3);

        // Road change mid-count, then idle, then restart
        applyStimulus(5'b10000, SB, S0, S0, S9);
        checkOutput("roadB_road", {30'b0, road}, 32'd2);
        checkOutput("roadB_total", {24'b0, errTotal}, 32'd3);
        applyStimulus(5'b10000, S0, S0, S0, S0);
        checkOutput("idle_road", {30'b0, road}, 32'd0);
        checkOutput("idle_remain", {28'b0, remain}, 32'd0);
        checkOutput("idle_total", {24'b0, errTotal}, 32'd3);
        applyStimulus(5'b10000, SB, S0, S0, S3);
        checkOutput("after_idle_road", {30'b0, road}, 32'd2);
        checkOutput("after_idle_total", {24'b0, errTotal}, 32'd3);

        // Reset with a tick in flight
        @(negedge clk);
        led = 5'b10000; seg4 = SC; seg1 = S8;
        counter = ~counter;
        repeat (2) @(negedge clk);
        resN = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_road", {30'b0, road}, 32'd0);
        checkOutput("mid_rst_digits", {20'b0, digit3, digit2, digit1}, 32'd0);
        checkOutput("mid_rst_remain", {28'b0, remain}, 32'd0);
        checkOutput("mid_rst_tick", {31'b0, tickPulse}, 32'd0);
        checkOutput("mid_rst_flags", {29'b0, errSeg, errLed, errCount}, 32'd0);
        checkOutput("mid_rst_total", {24'b0, errTotal}, 32'd0);
        counter = 1'b0;
        repeat (2) @(negedge clk);
        resN = 1'b1;
        sawPulse = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tickPulse) sawPulse = 1'b1;
        end
        checkOutput("inflight_discarded", {31'b0, sawPulse}, 32'd0);

        // Reload from 0 is exempt from the count check
        applyStimulus(5'b10000, SA, S0, S0, S1);
        checkOutput("reload_first", {24'b0, errTotal}, 32'd0);
        applyStimulus(5'b10000, SA, S0, S0, S0);
        checkOutput("reload_zero", {31'b0, errCount}, 32'd0);
        applyStimulus(5'b10000, SA, S0, S0, SE);
        checkOutput("reload_remain", {28'b0, remain}, 32'd14);
        checkOutput("reload_count", {31'b0, errCount}, 32'd0);
        checkOutput("reload_total", {24'b0, errTotal}, 32'd0);

        // 300 erroring ticks; the first carries two error types
        for (int k = 1; k <= 300; k++) begin
            applyStimulus(5'b10000, SA, S0, S0, BAD);
            if (k == 1) begin
                checkOutput("sat_first_total", {24'b0, errTotal}, 32'd1);
                checkOutput("sat_first_flags", {29'b0, errSeg, errLed, errCount}, 32'b101);
            end
            if (k == 254) checkOutput("sat_254", {24'b0, errTotal}, 32'd254);
            if (k == 255) checkOutput("sat_255", {24'b0, errTotal}, 32'd255);
        end
        checkOutput("sat_hold", {24'b0, errTotal}, 32'd255);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

- Passive checker on the traffic-light board outputs.
- Samples `LED`, `Seg1`–`Seg4` once per controller tick, marked by each toggle of `Counter`.
- Decodes the active-low 7-segment patterns back to nibbles and exposes road, digits and remaining time.
- Flags illegal segment codes, illegal lamp patterns and broken countdown sequences; used on-board and in system benches.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `Counter`; legal values 2–3.
- `CLK_50MHz` in 1: system clock.
- `Res_n` in 1: asynchronous, active-low reset.
- `Counter` in 1: controller tick marker; every edge is one tick.
- `LED` in 5: lamp pattern under observation.
- `Seg4`, `Seg3`, `Seg2`, `Seg1` in 7 each: active-low segment codes under observation.
- `Road` out 2: 0 idle, 1 A, 2 B, 3 C.
- `Digit3`, `Digit2`, `Digit1` out 4 each: decoded `Seg3`, `Seg2`, `Seg1`.
- `Remain` out 4: max(`Digit1`, `Digit2`, `Digit3`).
- `Tick_Pulse` out 1: one-cycle strobe when new sample results are valid.
- `Err_Seg`, `Err_LED`, `Err_Count` out 1 each: sticky error flags.
- `Err_Total` out 8: saturating count of ticks with any error.

## Operation
- **Tick detection:** `Counter` passes through `SYNC_STAGES` flops. Any edge (XOR of the last two stages) means tick detected.
- **Capture:** on a detected tick, `LED` and all four `Seg` inputs are registered. Inputs are stable for about 1 s, so they are not synchronized.
- **Decode:** each `Seg` code maps through the 16-entry table:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110
  - Any other code is invalid: the decoded value is 0 and `Err_Seg` sets.
- **Road:** `Seg4` decoding to A, B or C gives `Road` 1, 2 or 3. `Seg4`=0 gives idle (`Road`=0). Any other valid digit sets `Err_Seg`.
- **Idle samples:** when `Road`=0, no LED or count checks run and the previous-sample context is invalidated.
- **LED check:** legal patterns are 00011, 01000, 10100, 10000, 00100. Anything else sets `Err_LED`.
- **Count check:** applied only when all of the following hold:
  - the previous sample is valid;
  - `Road` is unchanged;
  - `LED` is unchanged;
  - the previous `Remain` ≠ 0.
  - Then the new `Remain` must equal previous − 1; otherwise `Err_Count` sets.
  - Previous `Remain`=0 counts as a phase reload and is exempt.
- **Context:** after each non-idle sample, `Road`, `LED` and `Remain` are stored as previous, and the previous-valid bit sets.
- **Error flags:** stay set until reset. Any number of error types can set on the same tick.
- **`Err_Total`:** increments by exactly 1 per tick with at least one error, saturating at 255.

## Timing
- **Reset values:** `Road`=0, digits=0, `Remain`=0, `Tick_Pulse`=0, all error flags=0, `Err_Total`=0. Previous-valid and synchronizer flops are cleared.
- **Latency:** for a `Counter` toggle sampled at clock edge t (with `SYNC_STAGES`=2):
  - edge detection at t+2;
  - inputs captured at t+3;
  - decoded outputs, error flags and `Tick_Pulse` valid from t+4 for exactly one cycle of `Tick_Pulse`.
- Decoded outputs hold until the next tick.
- The first tick after reset never runs a count check.
- A `Counter` toggle must not arrive within `SYNC_STAGES`+2 cycles of the previous one. Behaviour under closer toggles is unspecified.
- **Reset mid-operation:** any in-flight tick is discarded and all state returns to reset values.

## Structure
- **Package `traffic_light_pkg`:** the 16 segment-code constants, the 5 legal LED pattern constants, and the road-code constants (IDLE, A, B, C).
- **Sub-module `seg7_decoder`:** combinational; 7-bit code in, 4-bit value and valid bit out; instantiated four times.
- **Top level:** synchronizer, edge detect, capture registers, check logic, and the error counter.

## Test plan
1. **Road A cycle:** drive Road A's 21-step sequence (`Seg2` 5→1 with LED 00011, … , all-zero with LED 00011) for two full cycles. Required: no errors, `Road`=1, `Remain` follows 5,4,3,2,1,2,1,D,C,…,1,0,5.
2. **Bad segment code:** inject `Seg1`=1111111 on one tick. Required: `Err_Seg`=1, `Digit1`=0, `Err_Total`=1, and the flag is still set after 5 clean ticks.
3. **Illegal lamps:** `LED`=11111 with otherwise legal values. Required: `Err_LED`=1 only, and `Err_Total` increments once.
4. **Skipped count:** `Remain` goes 9 then 7 with LED 10000 held. Required: `Err_Count`=1. A separate case with 0 then E under the same LED produces no error.
5. **Road change and idle:** a road switch from A to B mid-count, and a `Seg4`=0 idle sample. Required: no count error on either transition sample, and `Road` updates to 2 / 0.
6. **Reset and saturation:** assert `Res_n` low mid-run; all outputs read reset values. Then 300 consecutive erroring ticks; `Err_Total` holds at 255.
